// File: rtl/pipeacc16_pkg.sv
// Shared constants for the pipeAcc16 data-memory path.
// dmem_arbiter's optional perf counters are enabled by defining DMEM_ARB_PERF_EN.
package pipeacc16_pkg;
    localparam int ADDR_W_DEF      = 8;
    localparam int DATA_W_DEF      = 16;
    localparam int MAX_CPU_RUN_DEF = 4;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_DBG = 1'b1;
endpackage

// File: rtl/dmem_arb_starve_ctr.sv
// Saturating count of CPU grants taken while DBG waits; raises force_dbg at the limit.
module dmem_arb_starve_ctr #(
    parameter int MAX_CPU_RUN = 4
) (
    input  logic clk1,
    input  logic rst,
    input  logic dbg_req,
    input  logic cpu_gnt,
    input  logic dbg_gnt,
    output logic force_dbg
);
    localparam logic [3:0] MAX_CNT = 4'(MAX_CPU_RUN);

    logic [3:0] starve_cnt_q, starve_cnt_d;

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!dbg_req || dbg_gnt)
            starve_cnt_d = 4'd0;
        else if (cpu_gnt && starve_cnt_q < MAX_CNT)
            starve_cnt_d = starve_cnt_q + 4'd1;
    end

    always_ff @(posedge clk1) begin
        if (rst) starve_cnt_q <= 4'd0;
        else     starve_cnt_q <= starve_cnt_d;
    end

    // Depends only on registered count and the live request, never on grants.
    assign force_dbg = dbg_req && (starve_cnt_q == MAX_CNT);
endmodule

// File: rtl/dmem_arbiter.sv
// Two-port (CPU / DBG) arbiter in front of the single-port data memory.
// Optional DMEM_ARB_PERF_EN adds conflict_cnt and cpu_stall_cnt outputs.
module dmem_arbiter
    import pipeacc16_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int MAX_CPU_RUN = MAX_CPU_RUN_DEF
) (
    input  logic              clk1,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              cpu_hlt,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
`ifdef DMEM_ARB_PERF_EN
    output logic [15:0]       conflict_cnt,
    output logic [15:0]       cpu_stall_cnt,
`endif
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    logic force_dbg;

    dmem_arb_starve_ctr #(.MAX_CPU_RUN(MAX_CPU_RUN)) u_starve (
        .clk1      (clk1),
        .rst       (rst),
        .dbg_req   (dbg_req),
        .cpu_gnt   (cpu_gnt),
        .dbg_gnt   (dbg_gnt),
        .force_dbg (force_dbg)
    );

    always_comb begin
        cpu_gnt = 1'b0;
        dbg_gnt = 1'b0;
        if (!rst) begin
            if (cpu_hlt && dbg_req) dbg_gnt = 1'b1;
            else if (force_dbg)     dbg_gnt = 1'b1;
            else if (cpu_req)       cpu_gnt = 1'b1;
            else if (dbg_req)       dbg_gnt = 1'b1;
        end
    end

    assign cpu_stall = cpu_req & ~cpu_gnt;

    always_comb begin
        mem_en    = cpu_gnt | dbg_gnt;
        mem_we    = 1'b0;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        if (dbg_gnt) begin
            mem_we    = dbg_we;
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
        end else if (cpu_gnt) begin
            mem_we    = cpu_we;
        end
    end

    // Return path: one pending-read flag plus the owner of that read.
    logic              rd_pend_q, rd_pend_d;
    logic              owner_q, owner_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;

    always_comb begin
        rd_pend_d   = mem_en & ~mem_we;
        owner_d     = dbg_gnt ? OWN_DBG : OWN_CPU;
        cpu_rdata_d = cpu_rvalid ? mem_rdata : cpu_rdata_q;
        dbg_rdata_d = dbg_rvalid ? mem_rdata : dbg_rdata_q;
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            rd_pend_q   <= 1'b0;
            owner_q     <= OWN_CPU;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
        end else begin
            rd_pend_q   <= rd_pend_d;
            owner_q     <= owner_d;
            cpu_rdata_q <= cpu_rdata_d;
            dbg_rdata_q <= dbg_rdata_d;
        end
    end

    // Gating with rst drops a read that was in flight when reset arrived.
    assign cpu_rvalid = rd_pend_q & ~rst & (owner_q == OWN_CPU);
    assign dbg_rvalid = rd_pend_q & ~rst & (owner_q == OWN_DBG);
    assign cpu_rdata  = rst ? '0 : (cpu_rvalid ? mem_rdata : cpu_rdata_q);
    assign dbg_rdata  = rst ? '0 : (dbg_rvalid ? mem_rdata : dbg_rdata_q);

`ifdef DMEM_ARB_PERF_EN
    logic [15:0] conflict_cnt_q, conflict_cnt_d;
    logic [15:0] cpu_stall_cnt_q, cpu_stall_cnt_d;

    always_comb begin
        conflict_cnt_d  = conflict_cnt_q;
        cpu_stall_cnt_d = cpu_stall_cnt_q;
        if (cpu_req && dbg_req && conflict_cnt_q != 16'hFFFF)
            conflict_cnt_d = conflict_cnt_q + 16'd1;
        if (cpu_stall && cpu_stall_cnt_q != 16'hFFFF)
            cpu_stall_cnt_d = cpu_stall_cnt_q + 16'd1;
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            conflict_cnt_q  <= 16'd0;
            cpu_stall_cnt_q <= 16'd0;
        end else begin
            conflict_cnt_q  <= conflict_cnt_d;
            cpu_stall_cnt_q <= cpu_stall_cnt_d;
        end
    end

    assign conflict_cnt  = conflict_cnt_q;
    assign cpu_stall_cnt = cpu_stall_cnt_q;
`endif
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 1-cycle-latency data memory.
module tb_dmem_arbiter;
    logic        clk1 = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we, cpu_hlt;
    logic [7:0]  cpu_addr;
    logic [15:0] cpu_wdata;
    logic        cpu_gnt, cpu_stall, cpu_rvalid;
    logic [15:0] cpu_rdata;
    logic        dbg_req, dbg_we;
    logic [7:0]  dbg_addr;
    logic [15:0] dbg_wdata;
    logic        dbg_gnt, dbg_rvalid;
    logic [15:0] dbg_rdata;
    logic        mem_en, mem_we;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
`ifdef DMEM_ARB_PERF_EN
    logic [15:0] conflict_cnt, cpu_stall_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk1 = ~clk1;

    dmem_arbiter dut (
        .clk1(clk1), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .cpu_hlt(cpu_hlt),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
`ifdef DMEM_ARB_PERF_EN
        .conflict_cnt(conflict_cnt), .cpu_stall_cnt(cpu_stall_cnt),
`endif
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    logic [15:0] mem [256];
    always @(posedge clk1) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next edge; caller then drives and settles.
    task automatic step();
        @(posedge clk1);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        for (int a = 0; a < 256; a++) mem[a] = 16'h0;
        mem_rdata = 16'h0;
        rst = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h0; cpu_wdata = 16'h0; cpu_hlt = 1'b0;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = 8'h0; dbg_wdata = 16'h0;

        step(); step(); settle();
        chk("rst_cpu_gnt",   32'(cpu_gnt),    0);
        chk("rst_dbg_gnt",   32'(dbg_gnt),    0);
        chk("rst_mem_en",    32'(mem_en),     0);
        chk("rst_stall",     32'(cpu_stall),  1);
        chk("rst_cpu_rv",    32'(cpu_rvalid), 0);
        chk("rst_dbg_rv",    32'(dbg_rvalid), 0);
        chk("rst_cpu_rdata", 32'(cpu_rdata),  0);
        chk("rst_dbg_rdata", 32'(dbg_rdata),  0);

        // DBG preload with CPU idle
        step();
        rst = 1'b0; cpu_req = 1'b0;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 8'h01; dbg_wdata = 16'h0002;
        settle();
        chk("pre1_dbg_gnt", 32'(dbg_gnt),   1);
        chk("pre1_mem_en",  32'(mem_en),    1);
        chk("pre1_mem_we",  32'(mem_we),    1);
        chk("pre1_addr",    32'(mem_addr),  32'h01);
        chk("pre1_wdata",   32'(mem_wdata), 32'h0002);
        step();
        dbg_addr = 8'h02; dbg_wdata = 16'h0003;
        settle();
        chk("pre2_dbg_gnt", 32'(dbg_gnt),   1);
        chk("pre2_addr",    32'(mem_addr),  32'h02);
        step();
        dbg_req = 1'b0; dbg_we = 1'b0;
        settle();
        chk("wr_no_rvalid", 32'(dbg_rvalid), 0);
        chk("idle_mem_en",  32'(mem_en),     0);

        // CPU read of preloaded word
        step();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h01;
        settle();
        chk("cpurd_gnt",   32'(cpu_gnt),   1);
        chk("cpurd_stall", 32'(cpu_stall), 0);
        chk("cpurd_mem_we",32'(mem_we),    0);
        step();
        cpu_req = 1'b0;
        settle();
        chk("cpurd_rvalid", 32'(cpu_rvalid), 1);
        chk("cpurd_rdata",  32'(cpu_rdata),  32'h0002);
        chk("cpurd_dbg_rv", 32'(dbg_rvalid), 0);
        step(); settle();
        chk("cpurd_rv_1cyc", 32'(cpu_rvalid), 0);
        chk("cpurd_hold",    32'(cpu_rdata),  32'h0002);

        // DBG read back
        step();
        dbg_req = 1'b1; dbg_addr = 8'h02;
        settle();
        chk("dbgrd_gnt", 32'(dbg_gnt), 1);
        step();
        dbg_req = 1'b0;
        settle();
        chk("dbgrd_rvalid",  32'(dbg_rvalid), 1);
        chk("dbgrd_rdata",   32'(dbg_rdata),  32'h0003);
        chk("dbgrd_cpu_rv",  32'(cpu_rvalid), 0);
        chk("dbgrd_cpu_hold",32'(cpu_rdata),  32'h0002);

        // Continuous dual reads: CPU x4 then one forced DBG slot
        for (int i = 0; i < 10; i++) begin
            step();
            cpu_req = 1'b1; cpu_addr = 8'h01;
            dbg_req = 1'b1; dbg_addr = 8'h02;
            settle();
            chk($sformatf("dual%0d_cpu_gnt", i), 32'(cpu_gnt),   (i % 5 == 4) ? 0 : 1);
            chk($sformatf("dual%0d_dbg_gnt", i), 32'(dbg_gnt),   (i % 5 == 4) ? 1 : 0);
            chk($sformatf("dual%0d_stall", i),   32'(cpu_stall), (i % 5 == 4) ? 1 : 0);
            if (i > 0)
                chk($sformatf("dual%0d_dbg_rv", i), 32'(dbg_rvalid), (i % 5 == 0) ? 1 : 0);
        end
        step();
        cpu_req = 1'b0; dbg_req = 1'b0;
        settle();
        chk("dual_last_dbg_rdata", 32'(dbg_rdata), 32'h0003);
`ifdef DMEM_ARB_PERF_EN
        chk("perf_conflict", 32'(conflict_cnt),  10);
        chk("perf_stall",    32'(cpu_stall_cnt), 2);
`endif

        // HLT: DBG owns the memory, CPU stalls until release
        for (int i = 0; i < 3; i++) begin
            step();
            cpu_hlt = 1'b1; cpu_req = 1'b1; dbg_req = 1'b1;
            settle();
            chk($sformatf("hlt%0d_dbg_gnt", i), 32'(dbg_gnt),   1);
            chk($sformatf("hlt%0d_stall", i),   32'(cpu_stall), 1);
        end
        step();
        cpu_hlt = 1'b0;
        settle();
        chk("unhlt_cpu_gnt", 32'(cpu_gnt), 1);
        chk("unhlt_stall",   32'(cpu_stall), 0);

        // Reset lands while a DBG read is outstanding
        step();
        cpu_req = 1'b0; dbg_req = 1'b1; dbg_addr = 8'h01;
        settle();
        chk("rstrd_dbg_gnt", 32'(dbg_gnt), 1);
        step();
        rst = 1'b1; dbg_req = 1'b0;
        settle();
        chk("rstrd_dbg_rv",    32'(dbg_rvalid), 0);
        chk("rstrd_mem_en",    32'(mem_en),     0);
        chk("rstrd_dbg_rdata", 32'(dbg_rdata),  0);
        chk("rstrd_cpu_rdata", 32'(cpu_rdata),  0);
        step();
        rst = 1'b0;
        settle();
        chk("postrst_dbg_rv",    32'(dbg_rvalid), 0);
        chk("postrst_dbg_rdata", 32'(dbg_rdata),  0);
`ifdef DMEM_ARB_PERF_EN
        chk("postrst_conflict", 32'(conflict_cnt), 0);
`endif

        // Starvation count restarted at 0: CPU gets four slots again
        for (int i = 0; i < 5; i++) begin
            step();
            cpu_req = 1'b1; dbg_req = 1'b1;
            settle();
            chk($sformatf("post%0d_cpu_gnt", i), 32'(cpu_gnt), (i == 4) ? 0 : 1);
        end
        step();
        cpu_req = 1'b0; dbg_req = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
